// File: rtl/npc_ras_unit.sv
// Next-PC unit for the five-stage MIPS pipeline: owns F_PC, resolves D-stage redirects,
// and keeps a circular return-address stack so `jr $ra` can redirect without a forwarded $ra.
module npc_ras_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_PC    = 32'h0000_4180,
   parameter int          RAS_DEPTH = 8,
   parameter bit          RAS_EN    = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [2:0]                   br_type,
   input  logic                         br_taken,
   input  logic [31:0]                  D_PC,
   input  logic [31:0]                  offset,
   input  logic [25:0]                  imm26,
   input  logic [31:0]                  rs_val,
   input  logic                         rs_is_ra,
   input  logic                         exc_req,
   input  logic                         eret,
   input  logic [31:0]                  epc,
   output logic [31:0]                  F_PC,
   output logic [31:0]                  npc,
   output logic [31:0]                  PC8,
   output logic                         ras_used,
   output logic                         ras_mispredict,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   localparam logic [2:0] BR_B    = 3'd1;
   localparam logic [2:0] BR_J    = 3'd2;
   localparam logic [2:0] BR_JAL  = 3'd3;
   localparam logic [2:0] BR_JR   = 3'd4;
   localparam logic [2:0] BR_JALR = 3'd5;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   ras_q [RAS_DEPTH];
   logic [31:0]   ras_d [RAS_DEPTH];
   logic [PW-1:0] tp_q, tp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mis_q, mis_d;

   logic [PW-1:0] top_idx_s;
   logic [31:0]   ras_top_s;
   logic          ras_avail_s;
   logic [31:0]   pc4_s;
   logic [31:0]   pc8_s;
   logic [31:0]   npc_s;
   logic          ras_used_s;
   logic          upd_s;
   logic          do_push_s;
   logic          do_pop_s;

   // Next-PC selection in priority order; the RAS top is the newest entry, one below tp.
   always_comb begin
      top_idx_s   = tp_q - PW'(1);
      ras_top_s   = ras_q[top_idx_s];
      ras_avail_s = (cnt_q != CW'(0));
      pc4_s       = pc_q + 32'd4;
      pc8_s       = D_PC + 32'd8;
      npc_s       = pc4_s;
      ras_used_s  = 1'b0;
      if (exc_req) begin
         npc_s = EXC_PC;
      end else if (eret) begin
         npc_s = epc;
      end else begin
         case (br_type)
            BR_B: begin
               if (br_taken) begin
                  npc_s = D_PC + 32'd4 + {offset[29:0], 2'b00};
               end else begin
                  npc_s = pc4_s;
               end
            end
            BR_J, BR_JAL: npc_s = {D_PC[31:28], imm26, 2'b00};
            BR_JR: begin
               if (RAS_EN && rs_is_ra && ras_avail_s) begin
                  npc_s      = ras_top_s;
                  ras_used_s = 1'b1;
               end else begin
                  npc_s = rs_val;
               end
            end
            BR_JALR: npc_s = rs_val;
            default: npc_s = pc4_s;
         endcase
      end
   end

   // Stack maintenance happens only on edges that actually retire the D-stage control transfer.
   always_comb begin
      upd_s     = !stall && !exc_req && !eret;
      do_push_s = upd_s && ((br_type == BR_JAL) || (br_type == BR_JALR));
      do_pop_s  = upd_s && (br_type == BR_JR) && rs_is_ra && ras_avail_s;
      ras_d     = ras_q;
      tp_d      = tp_q;
      cnt_d     = cnt_q;
      if (do_push_s) begin
         ras_d[tp_q] = pc8_s;
         tp_d        = tp_q + PW'(1);
         if (cnt_q != DEPTH_C) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else if (do_pop_s) begin
         tp_d  = top_idx_s;
         cnt_d = cnt_q - CW'(1);
      end else begin
         tp_d  = tp_q;
         cnt_d = cnt_q;
      end
      if (do_pop_s) begin
         mis_d = RAS_EN ? (ras_top_s != rs_val) : 1'b0;
      end else if (!stall) begin
         mis_d = 1'b0;
      end else begin
         mis_d = mis_q;
      end
      if (exc_req || !stall) begin
         pc_d = npc_s;
      end else begin
         pc_d = pc_q;
      end
   end

   // Control state: PC, stack pointer, occupancy and mispredict flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         tp_q  <= '0;
         cnt_q <= '0;
         mis_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         mis_q <= mis_d;
      end
   end

   // Stack storage needs no reset: entries are only read when the count says they are valid.
   always_ff @(posedge clk) begin
      ras_q <= ras_d;
   end

   assign F_PC           = pc_q;
   assign npc            = npc_s;
   assign PC8            = pc8_s;
   assign ras_used       = ras_used_s;
   assign ras_mispredict = mis_q;
   assign ras_count      = cnt_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit (RAS_DEPTH=4) with hand-computed expected values.
module tb_npc_ras_unit;

   logic        clk = 1'b0;
   logic        reset, stall, br_taken, rs_is_ra, exc_req, eret;
   logic [2:0]  br_type;
   logic [31:0] D_PC, offset, rs_val, epc;
   logic [25:0] imm26;
   logic [31:0] F_PC, npc, PC8;
   logic        ras_used, ras_mispredict;
   logic [2:0]  ras_count;

   int checks = 0;
   int errors = 0;

   npc_ras_unit #(.RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_type(br_type), .br_taken(br_taken),
      .D_PC(D_PC), .offset(offset), .imm26(imm26), .rs_val(rs_val), .rs_is_ra(rs_is_ra),
      .exc_req(exc_req), .eret(eret), .epc(epc), .F_PC(F_PC), .npc(npc), .PC8(PC8),
      .ras_used(ras_used), .ras_mispredict(ras_mispredict), .ras_count(ras_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] jal_pcs [5];
   logic [31:0] pop_exp [4];
   logic [2:0]  pop_cnt [4];
   logic        pop_mis [4];

   initial begin
      reset = 1'b1; stall = 1'b0; br_type = 3'd0; br_taken = 1'b0; rs_is_ra = 1'b0;
      exc_req = 1'b0; eret = 1'b0; D_PC = 32'd0; offset = 32'd0; rs_val = 32'd0;
      epc = 32'd0; imm26 = 26'h0000C40;
      #2;
      tick();
      check("rst_fpc", F_PC, 32'h0000_3000);
      check("rst_cnt", {29'd0, ras_count}, 32'd3 - 32'd3);
      check("rst_mis", {31'd0, ras_mispredict}, 32'd0);
      reset = 1'b0;

      for (int i = 1; i <= 3; i++) begin
         tick();
         check("seq_fpc", F_PC, 32'h0000_3000 + 32'(4 * i));
      end
      check("seq_cnt", {29'd0, ras_count}, 32'd0);

      // Taken branch backwards, then two PC4 steps to reach F_PC=0x3014
      D_PC = 32'h0000_3010; br_type = 3'd1; offset = 32'hFFFF_FFFE; br_taken = 1'b1;
      #1 check("b_taken", npc, 32'h0000_300C);
      tick();
      check("b_fpc", F_PC, 32'h0000_300C);
      br_type = 3'd0; tick(); tick();
      check("pre_nt", F_PC, 32'h0000_3014);
      br_type = 3'd1; br_taken = 1'b0;
      #1 check("b_not", npc, 32'h0000_3018);
      tick();

      // Jump with upper bits from D_PC
      D_PC = 32'hA000_0000; br_type = 3'd2;
      #1 check("j_tgt", npc, 32'hA000_3100);

      // JAL then JR $ra with a wrong rs_val
      D_PC = 32'h0000_3000; br_type = 3'd3;
      #1 check("jal_tgt", npc, 32'h0000_3100);
      check("jal_pc8", PC8, 32'h0000_3008);
      tick();
      check("jal_cnt", {29'd0, ras_count}, 32'd1);
      br_type = 3'd4; rs_is_ra = 1'b1; rs_val = 32'h0000_DEAD;
      #1 check("jr_npc", npc, 32'h0000_3008);
      check("jr_used", {31'd0, ras_used}, 32'd1);
      tick();
      check("jr_mis", {31'd0, ras_mispredict}, 32'd1);
      check("jr_cnt", {29'd0, ras_count}, 32'd0);
      check("jr_fpc", F_PC, 32'h0000_3008);
      br_type = 3'd0; rs_is_ra = 1'b0;
      tick();
      check("mis_clr", {31'd0, ras_mispredict}, 32'd0);

      // Stalled JAL: no PC change, no push; exception overrides stall
      br_type = 3'd3; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_fpc", F_PC, 32'h0000_300C);
      end
      check("stall_cnt", {29'd0, ras_count}, 32'd0);
      exc_req = 1'b1;
      #1 check("exc_npc", npc, 32'h0000_4180);
      tick();
      check("exc_fpc", F_PC, 32'h0000_4180);
      check("exc_cnt", {29'd0, ras_count}, 32'd0);
      exc_req = 1'b0; stall = 1'b0;

      // Overflow: five JALs into a four-entry stack
      for (int i = 0; i < 5; i++) jal_pcs[i] = 32'h0000_3000 + 32'(16 * i);
      for (int i = 0; i < 5; i++) begin
         D_PC = jal_pcs[i]; br_type = 3'd3;
         tick();
         check("ovf_cnt", {29'd0, ras_count}, (i < 4) ? 32'(i + 1) : 32'd4);
      end
      pop_exp[0] = 32'h0000_3048; pop_exp[1] = 32'h0000_3038;
      pop_exp[2] = 32'h0000_3028; pop_exp[3] = 32'h0000_3018;
      pop_cnt[0] = 3'd3; pop_cnt[1] = 3'd2; pop_cnt[2] = 3'd1; pop_cnt[3] = 3'd0;
      pop_mis[0] = 1'b0; pop_mis[1] = 1'b1; pop_mis[2] = 1'b1; pop_mis[3] = 1'b1;
      br_type = 3'd4; rs_is_ra = 1'b1; rs_val = 32'h0000_3048;
      for (int i = 0; i < 4; i++) begin
         #1 check("pop_npc", npc, pop_exp[i]);
         tick();
         check("pop_cnt", {29'd0, ras_count}, {29'd0, pop_cnt[i]});
         check("pop_mis", {31'd0, ras_mispredict}, {31'd0, pop_mis[i]});
      end
      #1 check("empty_npc", npc, 32'h0000_3048);
      check("empty_used", {31'd0, ras_used}, 32'd0);
      tick();
      check("empty_cnt", {29'd0, ras_count}, 32'd0);
      check("empty_mis", {31'd0, ras_mispredict}, 32'd0);

      // eret
      br_type = 3'd0; rs_is_ra = 1'b0; eret = 1'b1; epc = 32'h0000_3100;
      #1 check("eret_npc", npc, 32'h0000_3100);
      tick();
      check("eret_fpc", F_PC, 32'h0000_3100);
      eret = 1'b0;

      // JAL then JALR $ra: JALR takes rs_val and pushes without popping
      D_PC = 32'h0000_3200; br_type = 3'd3;
      tick();
      br_type = 3'd5; rs_is_ra = 1'b1; rs_val = 32'h0000_5550;
      #1 check("jalr_npc", npc, 32'h0000_5550);
      check("jalr_used", {31'd0, ras_used}, 32'd0);
      tick();
      check("jalr_cnt", {29'd0, ras_count}, 32'd2);
      br_type = 3'd3; rs_is_ra = 1'b0;
      tick();
      check("pre_rst_cnt", {29'd0, ras_count}, 32'd3);

      // Mid-sequence reset
      reset = 1'b1;
      tick();
      check("mrst_fpc", F_PC, 32'h0000_3000);
      check("mrst_cnt", {29'd0, ras_count}, 32'd0);
      reset = 1'b0; br_type = 3'd4; rs_is_ra = 1'b1; rs_val = 32'h0000_1234;
      #1 check("mrst_jr", npc, 32'h0000_1234);
      check("mrst_used", {31'd0, ras_used}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
